// File: rtl/run_harness_pkg.sv
// Shared types and width helpers for the run controller that clears, preloads,
// launches and checks the 8-bit processor.
package run_harness_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PRELOAD,
        LAUNCH,
        RUN,
        CHK_RD,
        CHK_CMP,
        DONE
    } state_t;

    localparam logic TBL_PRE = 1'b0;
    localparam logic TBL_CHK = 1'b1;

    // Error-count width; kept at one bit when there are no check entries.
    function automatic int err_width(input int n_chk);
        return (n_chk < 1) ? 1 : $clog2(n_chk + 1);
    endfunction

    function automatic int idx_width(input int n_pre, input int n_chk);
        int m;
        m = (n_pre > n_chk) ? n_pre : n_chk;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/run_harness_cmp.sv
// Check-phase comparator: latches the expected value during the read cycle,
// compares it against memory one cycle later and tracks error count / first error.
module run_harness_cmp
    import run_harness_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter int EW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] exp_data,
    input  logic [AW-1:0] exp_addr,
    input  logic          cmp,
    input  logic [DW-1:0] rdata,
    output logic [EW-1:0] err_cnt,
    output logic [AW-1:0] first_err_addr
);

    logic [DW-1:0] exp_reg;
    logic [AW-1:0] addr_reg;
    logic [EW-1:0] err_cnt_reg;
    logic [AW-1:0] first_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            exp_reg     <= '0;
            addr_reg    <= '0;
            err_cnt_reg <= '0;
            first_reg   <= '0;
        end else begin
            if (load) begin
                exp_reg  <= exp_data;
                addr_reg <= exp_addr;
            end
            if (cmp && (rdata != exp_reg)) begin
                if (err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
                // Only the first mismatch of a run is remembered.
                if (err_cnt_reg == '0) first_reg <= addr_reg;
            end
        end
    end

    assign err_cnt        = err_cnt_reg;
    assign first_err_addr = first_reg;

endmodule

// File: rtl/run_harness.sv
// Run controller: on GO clears data memory, writes the preload table, pulses the
// processor START, waits for DONE (with timeout) and checks the result table.
module run_harness
    import run_harness_pkg::*;
#(
    parameter int DW          = 8,
    parameter int AW          = 8,
    parameter int N_PRE       = 16,
    parameter int N_CHK       = 8,
    parameter int START_CYC   = 2,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CW          = 32,
    parameter int IW          = idx_width(N_PRE, N_CHK)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         go,
    output logic                         tbl_sel,
    output logic [IW-1:0]                tbl_idx,
    input  logic [AW-1:0]                tbl_addr,
    input  logic [DW-1:0]                tbl_data,
    output logic                         mem_we,
    output logic [AW-1:0]                mem_addr,
    output logic [DW-1:0]                mem_wdata,
    input  logic [DW-1:0]                mem_rdata,
    output logic                         dut_start,
    input  logic                         dut_done,
    output logic                         busy,
    output logic                         pass,
    output logic                         fail,
    output logic                         timeout,
    output logic [err_width(N_CHK)-1:0]  err_cnt,
    output logic [AW-1:0]                first_err_addr,
    output logic [CW-1:0]                cycles
);

    localparam int            EW       = err_width(N_CHK);
    localparam int            MEM_LAST = (1 << AW) - 1;
    localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT_CYC);

    state_t        state_reg, state_next;
    logic [31:0]   cnt_reg, cnt_next;
    logic [CW-1:0] cycles_reg, cycles_next;
    logic          timeout_reg, timeout_next;
    logic          start_clr;
    logic          results_ok;

    assign start_clr = go && ((state_reg == IDLE) || (state_reg == DONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            cycles_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cycles_reg  <= cycles_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cycles_next  = cycles_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (go) begin
                    state_next   = CLEAR;
                    cnt_next     = '0;
                    cycles_next  = '0;
                    timeout_next = 1'b0;
                end
            end
            CLEAR: begin
                if (cnt_reg == 32'(MEM_LAST)) begin
                    cnt_next   = '0;
                    state_next = (N_PRE == 0) ? LAUNCH : PRELOAD;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            PRELOAD: begin
                if (cnt_reg == 32'(N_PRE - 1)) begin
                    cnt_next   = '0;
                    state_next = LAUNCH;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            LAUNCH: begin
                if (cnt_reg == 32'(START_CYC - 1)) begin
                    cnt_next   = '0;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end
            RUN: begin
                // DONE takes priority over a timeout landing in the same cycle.
                if (dut_done) begin
                    state_next = (N_CHK == 0) ? DONE : CHK_RD;
                end else begin
                    if (cycles_reg != '1) cycles_next = cycles_reg + 1'b1;
                    if ((TIMEOUT_CYC != 0) && (cycles_next == TO_LIM)) begin
                        state_next   = DONE;
                        timeout_next = 1'b1;
                    end
                end
            end
            CHK_RD: begin
                state_next = CHK_CMP;
            end
            CHK_CMP: begin
                if (cnt_reg == 32'(N_CHK - 1)) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next   = cnt_reg + 32'd1;
                    state_next = CHK_RD;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Memory and table ports are decoded straight from state so a reset
    // silences them on the very next cycle.
    always_comb begin
        tbl_sel    = TBL_PRE;
        tbl_idx    = '0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        results_ok = (err_cnt == '0) && !timeout_reg;
        case (state_reg)
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = cnt_reg[AW-1:0];
            end
            PRELOAD: begin
                tbl_idx   = cnt_reg[IW-1:0];
                mem_we    = 1'b1;
                mem_addr  = tbl_addr;
                mem_wdata = tbl_data;
            end
            CHK_RD: begin
                tbl_sel  = TBL_CHK;
                tbl_idx  = cnt_reg[IW-1:0];
                mem_addr = tbl_addr;
            end
            default: ;
        endcase
        dut_start = !(state_reg inside {RUN, CHK_RD, CHK_CMP});
        busy      = !(state_reg inside {IDLE, DONE});
        pass      = (state_reg == DONE) && results_ok;
        fail      = (state_reg == DONE) && !results_ok;
    end

    assign timeout = timeout_reg;
    assign cycles  = cycles_reg;

    run_harness_cmp #(
        .DW(DW),
        .AW(AW),
        .EW(EW)
    ) u_cmp (
        .clk           (clk),
        .reset         (reset),
        .clr           (start_clr),
        .load          (state_reg == CHK_RD),
        .exp_data      (tbl_data),
        .exp_addr      (tbl_addr),
        .cmp           (state_reg == CHK_CMP),
        .rdata         (mem_rdata),
        .err_cnt       (err_cnt),
        .first_err_addr(first_err_addr)
    );

endmodule

// File: tb/tb_run_harness.sv
// Scoreboard bench for run_harness: a memory/processor stub, a last-writer-wins
// reference model per run, and a monitor that checks each completed run.
module tb_run_harness;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0;

    logic        tbl_sel;
    logic [1:0]  tbl_idx;
    logic [7:0]  tbl_addr, tbl_data;
    logic        mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic        dut_start, dut_done, busy, pass, fail, timeout;
    logic [1:0]  err_cnt;
    logic [7:0]  first_err_addr;
    logic [31:0] cycles;

    logic [7:0] pre_addr [4];
    logic [7:0] pre_data [4];
    logic [7:0] chk_addr [4];
    logic [7:0] chk_data [4];
    logic [7:0] stub_addr, stub_val;
    logic       done_en;
    int         delay;
    logic [7:0] mem [256];
    logic [7:0] exp_mem [256];
    int         run_n;
    int         cyc;
    int         n_vec;
    int         n_err;

    typedef struct packed {
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [1:0]  err;
        logic [7:0]  first;
        logic [31:0] cycles;
        logic [31:0] lat;
        logic [31:0] lo;
        logic [31:0] go_cyc;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Data memory plus a processor stub that writes one word at RUN start.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (!dut_start && run_n == 0) mem[stub_addr] <= stub_val;
        mem_rdata <= mem[mem_addr];
        run_n <= dut_start ? 0 : run_n + 1;
    end

    assign dut_done = done_en && !dut_start && (run_n >= delay);
    assign tbl_addr = tbl_sel ? chk_addr[tbl_idx] : pre_addr[tbl_idx];
    assign tbl_data = tbl_sel ? chk_data[tbl_idx] : pre_data[tbl_idx];

    run_harness #(
        .DW(8), .AW(8), .N_PRE(4), .N_CHK(3), .START_CYC(2),
        .TIMEOUT_CYC(100), .CW(32)
    ) dut (
        .clk(clk), .reset(reset), .go(go),
        .tbl_sel(tbl_sel), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .dut_start(dut_start), .dut_done(dut_done), .busy(busy), .pass(pass), .fail(fail),
        .timeout(timeout), .err_cnt(err_cnt), .first_err_addr(first_err_addr), .cycles(cycles)
    );

    // Degenerate configuration: empty tables, no timeout.
    logic        z_go = 1'b0;
    logic        z_sel, z_we, z_start, z_done, z_busy, z_pass, z_fail, z_tmo;
    logic [0:0]  z_idx, z_err;
    logic [3:0]  z_maddr, z_first;
    logic [7:0]  z_wdata;
    logic [15:0] z_cycles;
    int          z_run_n;

    always @(posedge clk) z_run_n <= z_start ? 0 : z_run_n + 1;
    assign z_done = !z_start && (z_run_n >= 5);

    run_harness #(
        .DW(8), .AW(4), .N_PRE(0), .N_CHK(0), .START_CYC(1),
        .TIMEOUT_CYC(0), .CW(16)
    ) u_zero (
        .clk(clk), .reset(reset), .go(z_go),
        .tbl_sel(z_sel), .tbl_idx(z_idx), .tbl_addr(4'd0), .tbl_data(8'd0),
        .mem_we(z_we), .mem_addr(z_maddr), .mem_wdata(z_wdata), .mem_rdata(8'd0),
        .dut_start(z_start), .dut_done(z_done), .busy(z_busy), .pass(z_pass), .fail(z_fail),
        .timeout(z_tmo), .err_cnt(z_err), .first_err_addr(z_first), .cycles(z_cycles)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_ctl"},
              64'({dut_start, mem_we, busy, tbl_sel, tbl_idx, mem_addr, mem_wdata}),
              64'({1'b1, 21'd0}));
        check({tag, "_res"},
              64'({pass, fail, timeout, err_cnt, first_err_addr, cycles}), 64'd0);
    endtask

    // Final memory content at an address: the last writer wins.
    function automatic logic [7:0] final_val(input logic [7:0] a);
        logic [7:0] v;
        v = 8'd0;
        for (int i = 0; i < 4; i++) if (pre_addr[i] == a) v = pre_data[i];
        if (stub_addr == a) v = stub_val;
        return v;
    endfunction

    // Monitor: on each entry into DONE, pop the expectation and compare.
    int   wr_cnt, rd_cnt, lo_cnt, wr_bad, mon_bad;
    logic done_prev;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset || (!busy && !pass && !fail)) begin
            wr_cnt = 0; rd_cnt = 0; lo_cnt = 0; wr_bad = 0; done_prev = 1'b0;
        end else begin
            if (mem_we) wr_cnt++;
            if (mem_we && (!busy || !dut_start)) wr_bad++;
            if (tbl_sel) rd_cnt++;
            if (!dut_start) lo_cnt++;
            if ((pass || fail) && !done_prev) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_done: got a finished run, expected none pending");
                end else begin
                    mon_e = sb.pop_front();
                    check("pass", 64'(pass), 64'(mon_e.pass));
                    check("fail", 64'(fail), 64'(mon_e.fail));
                    check("timeout", 64'(timeout), 64'(mon_e.tmo));
                    check("err_cnt", 64'(err_cnt), 64'(mon_e.err));
                    check("first_err_addr", 64'(first_err_addr), 64'(mon_e.first));
                    check("cycles", 64'(cycles), 64'(mon_e.cycles));
                    check("latency", 64'(32'(cyc) - mon_e.go_cyc + 32'd1), 64'(mon_e.lat));
                    check("start_low_cycles", 64'(lo_cnt), 64'(mon_e.lo));
                    check("start_in_done", 64'(dut_start), 64'd1);
                    check("write_count", 64'(wr_cnt), 64'(256 + 4));
                    check("stray_writes", 64'(wr_bad), 64'd0);
                    check("check_reads", 64'(rd_cnt), mon_e.tmo ? 64'd0 : 64'd3);
                    mon_bad = 0;
                    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) mon_bad++;
                    check("mem_image", 64'(mon_bad), 64'd0);
                    $display("run done: pass=%0d fail=%0d tmo=%0d err=%0d first=%0d cycles=%0d",
                             pass, fail, timeout, err_cnt, first_err_addr, cycles);
                end
                wr_cnt = 0; rd_cnt = 0; lo_cnt = 0; wr_bad = 0;
            end
            done_prev = pass || fail;
        end
    end

    task automatic do_run(input logic den, input int dly, input logic go_mid);
        exp_t e;
        int   errs;
        int   k;
        logic [7:0] first;
        done_en = den;
        delay   = dly;
        for (int a = 0; a < 256; a++) exp_mem[a] = final_val(8'(a));
        errs  = 0;
        first = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (final_val(chk_addr[i]) != chk_data[i]) begin
                if (errs == 0) first = chk_addr[i];
                errs++;
            end
        end
        if (!den) begin
            e.tmo = 1'b1; e.err = 2'd0; e.first = 8'd0; e.cycles = 32'd100;
            e.lo  = 32'd100;
            e.lat = 32'(1 + 256 + 4 + 2 + 100 + 1);
        end else begin
            e.tmo = 1'b0; e.err = errs[1:0]; e.first = first; e.cycles = 32'(dly);
            e.lo  = 32'(dly + 1 + 6);
            e.lat = 32'(1 + 256 + 4 + 2 + (dly + 1) + 2 * 3 + 1);
        end
        e.pass = !e.tmo && (errs == 0);
        e.fail = !e.pass;
        @(negedge clk);
        go = 1'b1;
        e.go_cyc = 32'(cyc);
        sb.push_back(e);
        @(negedge clk);
        go = 1'b0;
        check("go_busy", 64'(busy), 64'd1);
        check("go_clear", 64'({pass, fail, timeout, err_cnt, first_err_addr, cycles}), 64'd0);
        if (go_mid) begin
            k = 0;
            while (!(busy && !dut_start) && k < 2000) begin @(negedge clk); k++; end
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        k = 0;
        while (!(pass || fail) && k < 3000) begin @(negedge clk); k++; end
        check("done_seen", 64'(pass || fail), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int k, zg, zw;
        done_en = 1'b0; delay = 2; stub_addr = 8'd0; stub_val = 8'd0;
        pre_addr = '{8'd0, 8'd1, 8'd2, 8'd3};
        pre_data = '{8'd85, 8'd5, 8'd85, 8'd5};
        chk_addr = '{8'd5, 8'd4, 8'd255, 8'd0};
        chk_data = '{8'd240, 8'd0, 8'd0, 8'd0};
        repeat (3) @(negedge clk);
        reset_check("init");
        reset = 1'b0;

        stub_addr = 8'd5; stub_val = 8'd240;
        do_run(1'b1, 20, 1'b0);

        stub_val = 8'd241;
        chk_addr = '{8'd5, 8'd6, 8'd7, 8'd0};
        chk_data = '{8'd240, 8'd0, 8'd9, 8'd0};
        do_run(1'b1, 20, 1'b0);

        do_run(1'b0, 20, 1'b0);

        pre_addr = '{8'd60, 8'd60, 8'd1, 8'd2};
        pre_data = '{8'd240, 8'd7, 8'd11, 8'd22};
        stub_addr = 8'd100; stub_val = 8'd3;
        chk_addr = '{8'd60, 8'd1, 8'd100, 8'd0};
        chk_data = '{8'd7, 8'd11, 8'd3, 8'd0};
        do_run(1'b1, 12, 1'b1);

        // Abort in the middle of the preload table.
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        k = 0;
        while (!(mem_we && busy && tbl_idx == 2'd2) && k < 1000) begin @(negedge clk); k++; end
        check("reach_preload_2", 64'(tbl_idx), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        reset_check("mid");
        @(negedge clk);
        reset = 1'b0;
        do_run(1'b1, 12, 1'b0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                pre_addr[i] = 8'($urandom_range(0, 15));
                pre_data[i] = 8'($urandom);
            end
            stub_addr = 8'($urandom_range(0, 20));
            stub_val  = 8'($urandom);
            for (int i = 0; i < 3; i++) begin
                chk_addr[i] = 8'($urandom_range(0, 20));
                chk_data[i] = ($urandom_range(0, 2) != 0) ? final_val(chk_addr[i]) : 8'($urandom);
            end
            do_run($urandom_range(0, 4) != 0, $urandom_range(2, 40), r[0]);
        end

        // Empty tables: straight to PASS with the minimal latency.
        @(negedge clk);
        z_go = 1'b1;
        zg = cyc;
        zw = 0;
        k = 0;
        @(negedge clk);
        z_go = 1'b0;
        while (!(z_pass || z_fail) && k < 500) begin
            if (z_we) zw++;
            @(negedge clk);
            k++;
        end
        check("zero_latency", 64'(cyc - zg + 1), 64'(1 + 16 + 0 + 1 + (5 + 1) + 2 * 0 + 1));
        check("zero_pass", 64'({z_pass, z_fail}), 64'(2'b10));
        check("zero_cycles", 64'(z_cycles), 64'd5);
        check("zero_writes", 64'(zw), 64'd16);
        check("zero_idle_outs",
              64'({z_sel, z_idx, z_wdata, z_maddr, z_err, z_first, z_tmo, z_busy, z_start}),
              64'd1);
        $display("zero-table run: pass=%0d cycles=%0d latency=%0d", z_pass, z_cycles, cyc - zg + 1);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
